// File: rtl/dir_toggle.sv
// Direction pushbutton conditioner: synchronizes and debounces btn_raw,
// then toggles the registered dir level once per clean press.
module dir_toggle #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic dir,
    output logic dir_chg,
    output logic btn_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1;
    logic          s2;

    // Two-flop synchronizer; only s2 is allowed to reach the debounce logic.
    always_ff @(posedge clk) begin
        if (nrst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debounce FSM. btn_db is updated on the same edges that enter HELD or
    // return to IDLE, so it is a pure register with no path from btn_raw.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            dir     <= 1'b0;
            dir_chg <= 1'b0;
            btn_db  <= 1'b0;
        end else begin
            dir_chg <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state   <= HELD;
                        dir     <= ~dir;
                        dir_chg <= 1'b1;
                        btn_db  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        state  <= IDLE;
                        btn_db <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    btn_db <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dir_toggle.md
# dir_toggle

Upstream input-conditioning stage for the up/down counter path: takes the raw, bouncing direction pushbutton, synchronizes and debounces it, and toggles a registered `dir` level on each clean press. `dir` drives the counter's direction input directly; `dir_chg` is a one-cycle strobe for logging or LED feedback. Runs on the undivided board clock so debounce timing is independent of the count-rate divider.

## Interface
- `DEBOUNCE_CYCLES`, default 250000, number of consecutive stable samples required to accept a level change (2.5 ms at 100 MHz); legal range 2 and up. The counter width is $clog2(DEBOUNCE_CYCLES).
- `clk`  input  1  board clock; all flops on its rising edge.
- `nrst`  input  1  reset, synchronous and active-high (1 = reset).
- `btn_raw`  input  1  asynchronous pushbutton, 1 = pressed.
- `dir`  output  1  registered direction level (0 = up, 1 = down); toggles once per debounced press.
- `dir_chg`  output  1  single-cycle pulse, high in the cycle after `dir` changes value.
- `btn_db`  output  1  debounced button level (1 while in HELD/RELEASE_WAIT).

## Operation
- Synchronizer: two flops, `btn_raw` -> `s1` -> `s2`; only `s2` feeds logic.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; debounce counter `cnt`.
- IDLE: `s2`=1 -> PRESS_WAIT, `cnt`<=0; else stay.
- PRESS_WAIT: `s2`=0 -> IDLE (bounce rejected, no toggle). `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1 -> HELD, `dir`<=~`dir`, `dir_chg`<=1. Otherwise `cnt`<=`cnt`+1.
- HELD: `s2`=0 -> RELEASE_WAIT, `cnt`<=0; else stay (holding never re-toggles, no auto-repeat).
- RELEASE_WAIT: `s2`=1 -> HELD (release bounce, no toggle). `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise `cnt`<=`cnt`+1.
- `btn_db` = 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT; registered/state-decoded with no combinational path from `btn_raw`.
- `dir_chg` defaults to 0 every cycle; it is set only on the PRESS_WAIT -> HELD transition.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- Reset (`nrst`=1 at an edge, in any state including mid-count): `s1`=`s2`=0, state=IDLE, `cnt`=0, `dir`=0, `dir_chg`=0, `btn_db`=0. A button still held when reset is released is treated as a new press and toggles `dir` to 1 after full debounce.

## Timing
- Number edges from edge 0, the first rising edge that samples `btn_raw`=1. If `btn_raw` stays 1, then:
  - `s2`=1 after edge 1.
  - The FSM enters PRESS_WAIT at edge 2.
  - `dir` toggles and `dir_chg` rises at edge DEBOUNCE_CYCLES+2.
  - `dir_chg` falls at the next edge.
- A press that drops `s2` before the accept edge produces no toggle. The minimum accepted press is DEBOUNCE_CYCLES+1 consecutive high samples of `s2`.
- Release: `btn_db` stays 1 until `s2` has been 0 for DEBOUNCE_CYCLES consecutive samples following the HELD exit edge.
- One toggle per press-release cycle. The earliest second toggle needs a full release debounce followed by a full press debounce.
- Reset takes priority over every transition at the same edge.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert `nrst` for 3 cycles with `btn_raw`=1, then release `nrst` and keep `btn_raw`=1. During reset `dir`=0, `dir_chg`=0, `btn_db`=0; after release the bench requires exactly one toggle (`dir`=1) with `dir_chg` high for one cycle.
- Clean press: after reset with `btn_raw`=0, raise `btn_raw` at edge 0 and hold it for 20 cycles. `dir` goes 0->1 at edge 6, `dir_chg` is high only during cycle 6-7, `btn_db`=1 from edge 6, and there are no further toggles while held.
- Bounce rejection: drive `btn_raw` as 1,1,0,1,1,0,1,0 followed by 0 for 20 cycles. `dir` stays 0, `dir_chg` never asserts, and `btn_db` stays 0.
- Release bounce: from HELD, drive `btn_raw` as 0,0,1,1 then hold 1. The FSM returns to HELD, `btn_db` stays 1, and `dir` does not change.
- Two full presses: each press holds `btn_raw`=1 for 10 cycles and each release holds 0 for 10 cycles. `dir` goes 0->1->0 with exactly two `dir_chg` pulses, and `btn_db` returns to 0 between presses.
- Reset mid-debounce: assert `nrst` while in PRESS_WAIT with `cnt`=2. The next cycle shows state IDLE, `dir` unchanged at 0, and `dir_chg` 0; a subsequent clean press gives the normal edge-6 toggle.
